sum_arbiter: RTL and testbench
==============================

// Module: sum_arbiter
// PURPOSE
//   Shares one signed W-bit adder between two requesters (channel 0 and channel 1).
//   Each requester presents a signed operand pair with a valid/ready handshake.
//   The block grants one request per cycle in round-robin order and returns a
//   registered W+1-bit sum, tagged with the requester ID, on a single result channel.
//   Per-channel saturating counters track completed grants for status and debug.
// PARAMETERS
//   W      4  operand width; signed, two's complement
//   CNT_W  8  width of each per-channel grant counter
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      synchronous reset, active low
//   REQ0_VALID   in   1      channel 0 holds an operand pair
//   REQ0_A       in   W      channel 0 operand A (signed)
//   REQ0_B       in   W      channel 0 operand B (signed)
//   REQ0_READY   out  1      channel 0 pair accepted this cycle
//   REQ1_VALID   in   1      channel 1 holds an operand pair
//   REQ1_A       in   W      channel 1 operand A (signed)
//   REQ1_B       in   W      channel 1 operand B (signed)
//   REQ1_READY   out  1      channel 1 pair accepted this cycle
//   RES_VALID    out  1      result register holds a result
//   RES_X        out  W+1    signed sum A+B
//   RES_ID       out  1      requester that produced RES_X
//   RES_READY    in   1      consumer takes the result this cycle
//   CNT0         out  CNT_W  completed grants to channel 0 (saturating)
//   CNT1         out  CNT_W  completed grants to channel 1 (saturating)
// BEHAVIOUR
//   - Reset (rst_n=0 at a clk edge): RES_VALID=0, RES_X=0, RES_ID=0, CNT0=CNT1=0,
//     and the priority pointer is set to channel 0. While rst_n=0, REQn_READY=0.
//   - Transfer rule: a channel transfers when VALID and READY are both 1 at a clk edge.
//     A requester holds VALID and operands stable until that channel transfers.
//   - Result-register FSM. EMPTY means RES_VALID=0; FULL means RES_VALID=1.
//     EMPTY -> FULL on a grant.
//     FULL -> EMPTY when RES_READY=1 and there is no grant.
//     FULL -> FULL when RES_READY=0 (hold), or when RES_READY=1 with a grant
//     (drain-through: the new result replaces the old one in the same cycle).
//   - can_accept = !RES_VALID | RES_READY. With no can_accept, both READYs are 0.
//   - Grant (combinational):
//     - If only one channel is valid, that channel is granted.
//     - If both are valid, the channel named by the priority pointer is granted.
//     - REQn_READY = grant_n & can_accept, so at most one READY is 1 per cycle.
//     - READY may depend combinationally on VALID. VALID must not depend on READY.
//   - Pointer: after a transfer on channel n, the pointer moves to channel 1-n.
//     With no transfer, it is unchanged.
//   - Latency: result appears 1 cycle after transfer.
//     RES_X = sign_ext(A) + sign_ext(B) in W+1 bits, so there is no overflow.
//     RES_ID = granted channel.
//     Sustained throughput: 1 result/cycle while RES_READY=1.
//   - RES_X and RES_ID hold stable while RES_VALID=1 and RES_READY=0.
//   - CNTn increments on a channel-n transfer and saturates at 2^CNT_W-1 (no wrap).
//   - Reset mid-operation: a pending result is discarded and the counters clear.
//     A request transferring in the reset cycle is dropped.
// TESTING
//   1. Reset then idle: rst_n=0 for 2 cycles -> RES_VALID=0, RES_X=0, CNT0=CNT1=0, READYs=0.
//   2. Single op: REQ0 A=-8, B=-8, RES_READY=1 -> REQ0_READY=1; next cycle RES_VALID=1,
//      RES_X=-16 (5'b10000), RES_ID=0. Repeat with A=7, B=7 -> RES_X=14.
//   3. Contention: both channels valid for 4 cycles, RES_READY=1 -> grants 0,1,0,1;
//      RES_ID sequence 0,1,0,1; CNT0=CNT1=2.
//   4. Backpressure: RES_READY=0 with a result held -> READYs stay 0 and RES_X is stable
//      for 5 cycles. Raise RES_READY with REQ1 valid -> drain-through: new result next cycle.
//   5. Saturation: CNT_W=2, channel 0 issues 6 ops -> CNT0 sticks at 3.
//   6. Reset mid-flight: RES_VALID=1, then rst_n=0 for 1 cycle -> RES_VALID=0,
//      pointer=0, counters=0.

Source files
------------

// File: rtl/sum_arbiter.sv
// Round-robin arbiter sharing one signed W-bit adder between two requesters.
// Results are registered (W+1 bits, never overflow) and tagged with the requester ID.
module sum_arbiter #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             REQ0_VALID,
    input  logic [W-1:0]     REQ0_A,
    input  logic [W-1:0]     REQ0_B,
    output logic             REQ0_READY,
    input  logic             REQ1_VALID,
    input  logic [W-1:0]     REQ1_A,
    input  logic [W-1:0]     REQ1_B,
    output logic             REQ1_READY,
    output logic             RES_VALID,
    output logic [W:0]       RES_X,
    output logic             RES_ID,
    input  logic             RES_READY,
    output logic [CNT_W-1:0] CNT0,
    output logic [CNT_W-1:0] CNT1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [W:0]       res_x_q, res_x_d;
    logic             res_id_q, res_id_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic       can_accept;
    logic       grant0, grant1;
    logic       xfer0, xfer1, xfer;
    logic [W:0] sum0, sum1;

    // Sign-extend both operands to W+1 bits so the sum can never overflow.
    assign sum0 = {REQ0_A[W-1], REQ0_A} + {REQ0_B[W-1], REQ0_B};
    assign sum1 = {REQ1_A[W-1], REQ1_A} + {REQ1_B[W-1], REQ1_B};

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        can_accept = (state_q == EMPTY) | RES_READY;
        grant0     = REQ0_VALID & (~REQ1_VALID | ~ptr_q);
        grant1     = REQ1_VALID & (~REQ0_VALID |  ptr_q);
        // READY is forced low while reset is asserted, so nothing is offered as accepted.
        REQ0_READY = rst_n & grant0 & can_accept;
        REQ1_READY = rst_n & grant1 & can_accept;
        xfer0      = REQ0_VALID & REQ0_READY;
        xfer1      = REQ1_VALID & REQ1_READY;
        xfer       = xfer0 | xfer1;
    end

    always_comb begin
        state_d  = state_q;
        res_x_d  = res_x_q;
        res_id_d = res_id_q;
        ptr_d    = ptr_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;

        unique case (state_q)
            EMPTY: if (xfer) state_d = FULL;
            FULL:  if (RES_READY && !xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase

        // A transfer while FULL and RES_READY=1 overwrites the result being drained.
        if (xfer) begin
            res_x_d  = xfer1 ? sum1 : sum0;
            res_id_d = xfer1;
            ptr_d    = ~xfer1;
        end

        if (xfer0 && cnt0_q != {CNT_W{1'b1}}) cnt0_d = cnt0_q + CNT_ONE;
        if (xfer1 && cnt1_q != {CNT_W{1'b1}}) cnt1_d = cnt1_q + CNT_ONE;
    end

    // NOTE: reset is sampled on the clock edge only, and all state updates use non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            res_x_q  <= '0;
            res_id_q <= 1'b0;
            ptr_q    <= 1'b0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            state_q  <= state_d;
            res_x_q  <= res_x_d;
            res_id_q <= res_id_d;
            ptr_q    <= ptr_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    assign RES_VALID = (state_q == FULL);
    assign RES_X     = res_x_q;
    assign RES_ID    = res_id_q;
    assign CNT0      = cnt0_q;
    assign CNT1      = cnt1_q;

endmodule

// File: tb/tb_sum_arbiter.sv
// Directed self-checking bench for sum_arbiter; a second instance with 2-bit
// counters shares the same stimulus and is used for the saturation checks.
module tb_sum_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid, res_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready, res_valid, res_id;
    logic [W:0]   res_x;
    logic [7:0]   cnt0, cnt1;

    logic         s_req0_ready, s_req1_ready, s_res_valid, s_res_id;
    logic [W:0]   s_res_x;
    logic [1:0]   s_cnt0, s_cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sum_arbiter #(.W(W), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .REQ0_VALID(req0_valid), .REQ0_A(req0_a), .REQ0_B(req0_b), .REQ0_READY(req0_ready),
        .REQ1_VALID(req1_valid), .REQ1_A(req1_a), .REQ1_B(req1_b), .REQ1_READY(req1_ready),
        .RES_VALID(res_valid), .RES_X(res_x), .RES_ID(res_id), .RES_READY(res_ready),
        .CNT0(cnt0), .CNT1(cnt1)
    );

    sum_arbiter #(.W(W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .REQ0_VALID(req0_valid), .REQ0_A(req0_a), .REQ0_B(req0_b), .REQ0_READY(s_req0_ready),
        .REQ1_VALID(req1_valid), .REQ1_A(req1_a), .REQ1_B(req1_b), .REQ1_READY(s_req1_ready),
        .RES_VALID(s_res_valid), .RES_X(s_res_x), .RES_ID(s_res_id), .RES_READY(res_ready),
        .CNT0(s_cnt0), .CNT1(s_cnt1)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] s5(input int v);
        return v[4:0];
    endfunction

    function automatic logic [3:0] s4(input int v);
        return v[3:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = s4(1); req0_b = s4(1);
        req1_valid = 1'b0; req1_a = '0;    req1_b = '0;

        // Reset then idle; a request offered during reset must see READY=0.
        tick(); tick();
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_valid", res_valid, 0);
        check("rst_x", res_x, 0);
        check("rst_id", res_id, 0);
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("idle_valid", res_valid, 0);

        // Single ops on channel 0, including both operand extremes.
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = s4(-8); req0_b = s4(-8);
        #1;
        check("op1_ready0", req0_ready, 1);
        check("op1_ready1", req1_ready, 0);
        tick();
        req0_a = s4(7); req0_b = s4(7);
        check("op1_valid", res_valid, 1);
        check("op1_x", res_x, s5(-16));
        check("op1_id", res_id, 0);
        check("op1_cnt0", cnt0, 1);
        check("op2_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        check("op2_valid", res_valid, 1);
        check("op2_x", res_x, s5(14));
        check("op2_cnt0", cnt0, 2);
        tick();
        check("drain_valid", res_valid, 0);

        // Contention: pointer starts at 0 after reset, grants alternate 0,1,0,1.
        reset_pulse();
        req0_valid = 1'b1; req0_a = s4(1);  req0_b = s4(2);
        req1_valid = 1'b1; req1_a = s4(-3); req1_b = s4(-4);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
            check("rr_ready1", req1_ready, (i % 2 == 1) ? 1 : 0);
            tick();
            check("rr_id", res_id, (i % 2 == 1) ? 1 : 0);
            check("rr_x", res_x, (i % 2 == 1) ? s5(-7) : s5(3));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_cnt0", cnt0, 2);
        check("rr_cnt1", cnt1, 2);
        tick();
        check("rr_drain", res_valid, 0);

        // Backpressure: held result must stay put, then drain-through on RES_READY.
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = s4(3); req0_b = s4(-5);
        #1;
        check("bp_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = s4(5); req1_b = s4(6);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_ready0_hold", req0_ready, 0);
            check("bp_ready1_hold", req1_ready, 0);
            check("bp_valid", res_valid, 1);
            check("bp_x", res_x, s5(-2));
            check("bp_id", res_id, 0);
            tick();
        end
        res_ready = 1'b1;
        #1;
        check("dt_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        check("dt_valid", res_valid, 1);
        check("dt_x", res_x, s5(11));
        check("dt_id", res_id, 1);
        check("dt_cnt0", cnt0, 3);
        check("dt_cnt1", cnt1, 3);

        // Saturation: 2-bit counter sticks at 3, 8-bit counter keeps counting.
        reset_pulse();
        req0_valid = 1'b1; req0_a = s4(2); req0_b = s4(-1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("sat_cnt0", s_cnt0, (i + 1 > 3) ? 3 : i + 1);
            check("sat_x", s_res_x, s5(1));
        end
        req0_valid = 1'b0;
        check("sat_cnt1", s_cnt1, 0);
        check("wide_cnt0", cnt0, 6);
        tick();
        check("sat_drain", res_valid, 0);

        // Reset mid-flight: pending result, pointer and counters cleared, reset-cycle request dropped.
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = s4(4); req0_b = s4(4);
        tick();
        req0_valid = 1'b0;
        check("mf_valid", res_valid, 1);
        check("mf_x", res_x, s5(8));
        rst_n = 1'b0;
        res_ready = 1'b1;
        req1_valid = 1'b1; req1_a = s4(1); req1_b = s4(1);
        #1;
        check("mf_rst_ready1", req1_ready, 0);
        tick();
        rst_n = 1'b1;
        req1_valid = 1'b0;
        check("mf_valid_clr", res_valid, 0);
        check("mf_x_clr", res_x, 0);
        check("mf_cnt0_clr", cnt0, 0);
        check("mf_cnt1_clr", cnt1, 0);
        check("mf_scnt0_clr", s_cnt0, 0);
        req0_valid = 1'b1; req0_a = s4(-1); req0_b = s4(-2);
        req1_valid = 1'b1; req1_a = s4(6);  req1_b = s4(1);
        #1;
        check("mf_ptr_ready0", req0_ready, 1);
        check("mf_ptr_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("mf_ptr_id", res_id, 0);
        check("mf_ptr_x", res_x, s5(-3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
